// File: rtl/effect_ctrl_pkg.sv
// effect_ctrl_pkg
// Shared definitions for the effect entry arbiter:
//   - arb_state_e       : arbiter FSM state encoding
//   - EFF_*             : effect index constants (bit positions in EffectOn/EffectReq/Grant)
//   - DEFAULT_VAL_W     : default parameter value width
//   - DEFAULT_MAX_VALUE : default clamp ceiling for entered values
//   - rr_pick()         : round-robin one-hot winner selection
package effect_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_WAIT  = 3'd2,
        S_APPLY = 3'd3,
        S_ABORT = 3'd4
    } arb_state_e;

    localparam int EFF_VOLUME     = 0;
    localparam int EFF_PITCH      = 1;
    localparam int EFF_DISTORTION = 2;

    localparam int DEFAULT_VAL_W     = 7;
    localparam int DEFAULT_MAX_VALUE = 100;

    // Search starts at the effect after last_idx and wraps, so the most
    // recent owner is always considered last.
    function automatic logic [2:0] rr_pick(input logic [2:0] eligible,
                                           input logic [1:0] last_idx);
        logic [2:0] pick;
        int         idx;
        pick = '0;
        for (int k = 1; k <= 3; k++) begin
            idx = (int'(last_idx) + k) % 3;
            if ((pick == 3'b000) && eligible[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/param_ramp.sv
// param_ramp
// One target-to-parameter path for a single effect.
//   Build macro: PARAM_RAMP_EN
//     defined   : param slews +/-1 toward target on each tick
//     undefined : param is a direct copy of target (no clock, reset or tick ports)
// Ports:
//   clk, rst  (ramp build only) clock, asynchronous active-high reset
//   tick      (ramp build only) one-cycle step enable shared by all instances
//   target    in  VAL_W  value the parameter should settle at
//   param     out VAL_W  live parameter to the datapath
module param_ramp
    import effect_ctrl_pkg::*;
#(
    parameter int VAL_W = DEFAULT_VAL_W
) (
`ifdef PARAM_RAMP_EN
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
`endif
    input  logic [VAL_W-1:0] target,
    output logic [VAL_W-1:0] param
);

`ifdef PARAM_RAMP_EN
    logic [VAL_W-1:0] param_q;
    logic [VAL_W-1:0] param_d;

    always_comb begin
        param_d = param_q;
        if (tick) begin
            if (param_q < target) begin
                param_d = param_q + 1'b1;
            end else if (param_q > target) begin
                param_d = param_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            param_q <= '0;
        end else begin
            param_q <= param_d;
        end
    end

    assign param = param_q;
`else
    assign param = target;
`endif

endmodule

// File: rtl/effect_entry_arbiter.sv
// effect_entry_arbiter
// Shares the numeric-entry engine between volume, pitch and distortion:
// round-robin grant, session start/supervise/retire, clamp and store the
// entered value as the owner's target, and drive the live parameters.
//   Build macro: PARAM_RAMP_EN (slewed parameters with a RAMP_DIV divider);
//   when undefined the parameters follow their targets directly.
// Ports:
//   Clock, Reset       clock, asynchronous active-high reset
//   EffectOn[2:0]      level enables (0 volume, 1 pitch, 2 distortion)
//   EffectReq[2:0]     level requests, qualified by EffectOn
//   entry_done         engine completion pulse, entry_value valid
//   entry_value        entered value, unclamped
//   Grant[2:0]         one-hot engine owner, 0 when idle
//   entry_start        one-cycle session start pulse
//   entry_abort        one-cycle session cancel pulse
//   Busy               high while a grant is held
//   *_param            live parameters
// Handshake: entry_done is a single-cycle qualifier for entry_value and is
// only honoured while a session is open (S_WAIT); pulses outside it are dropped.
module effect_entry_arbiter
    import effect_ctrl_pkg::*;
#(
    parameter int          VAL_W         = DEFAULT_VAL_W,
    parameter int          MAX_VALUE     = DEFAULT_MAX_VALUE,
    parameter logic [23:0] ENTRY_TIMEOUT = 24'd10_000_000,
    parameter logic [15:0] RAMP_DIV      = 16'd50_000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       EffectOn,
    input  logic [2:0]       EffectReq,
    input  logic             entry_done,
    input  logic [VAL_W-1:0] entry_value,
    output logic [2:0]       Grant,
    output logic             entry_start,
    output logic             entry_abort,
    output logic             Busy,
    output logic [VAL_W-1:0] volume_param,
    output logic [VAL_W-1:0] pitch_param,
    output logic [VAL_W-1:0] distortion_param
);

    localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VALUE);

    arb_state_e       state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_owner_q, last_owner_d;
    logic             start_q, start_d;
    logic             abort_q, abort_d;
    logic [23:0]      timer_q, timer_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic [VAL_W-1:0] target_q [3];
    logic [VAL_W-1:0] target_d [3];
    logic [2:0]       eligible;
    logic             owner_on;

    assign eligible = EffectReq & EffectOn;
    assign owner_on = |(EffectOn & grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        start_d      = 1'b0;
        abort_d      = 1'b0;
        timer_d      = timer_q;
        value_d      = value_q;
        target_d     = target_q;

        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    grant_d = rr_pick(eligible, last_owner_q);
                    owner_d = grant_d[2] ? 2'd2 : (grant_d[1] ? 2'd1 : 2'd0);
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 24'd1;
                // Abort is checked first so a coincident entry_done is discarded.
                if (!owner_on || (timer_q == ENTRY_TIMEOUT - 24'd1)) begin
                    abort_d = 1'b1;
                    state_d = S_ABORT;
                end else if (entry_done) begin
                    value_d = entry_value;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                for (int i = 0; i < 3; i++) begin
                    if (owner_q == 2'(i)) begin
                        target_d[i] = (value_q > MAX_V) ? MAX_V : value_q;
                    end
                end
                last_owner_d = owner_q;
                grant_d      = '0;
                state_d      = S_IDLE;
            end
            S_ABORT: begin
                last_owner_d = owner_q;
                grant_d      = '0;
                state_d      = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        // A disabled effect always reads back as zero, whatever the FSM does.
        for (int i = 0; i < 3; i++) begin
            if (!EffectOn[i]) begin
                target_d[i] = '0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd2;
            start_q      <= 1'b0;
            abort_q      <= 1'b0;
            timer_q      <= '0;
            value_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                target_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            start_q      <= start_d;
            abort_q      <= abort_d;
            timer_q      <= timer_d;
            value_q      <= value_d;
            target_q     <= target_d;
        end
    end

    assign Grant       = grant_q;
    assign Busy        = |grant_q;
    assign entry_start = start_q;
    assign entry_abort = abort_q;

`ifdef PARAM_RAMP_EN
    logic [15:0] div_q, div_d;
    logic        tick;

    assign tick = (div_q == RAMP_DIV - 16'd1);

    always_comb begin
        div_d = tick ? 16'd0 : div_q + 16'd1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    param_ramp #(.VAL_W(VAL_W)) u_ramp_volume (
        .clk(Clock), .rst(Reset), .tick(tick),
        .target(target_q[EFF_VOLUME]), .param(volume_param));
    param_ramp #(.VAL_W(VAL_W)) u_ramp_pitch (
        .clk(Clock), .rst(Reset), .tick(tick),
        .target(target_q[EFF_PITCH]), .param(pitch_param));
    param_ramp #(.VAL_W(VAL_W)) u_ramp_distortion (
        .clk(Clock), .rst(Reset), .tick(tick),
        .target(target_q[EFF_DISTORTION]), .param(distortion_param));
`else
    param_ramp #(.VAL_W(VAL_W)) u_ramp_volume (
        .target(target_q[EFF_VOLUME]), .param(volume_param));
    param_ramp #(.VAL_W(VAL_W)) u_ramp_pitch (
        .target(target_q[EFF_PITCH]), .param(pitch_param));
    param_ramp #(.VAL_W(VAL_W)) u_ramp_distortion (
        .target(target_q[EFF_DISTORTION]), .param(distortion_param));
`endif

endmodule

// File: tb/tb_effect_entry_arbiter.sv
// tb_effect_entry_arbiter
// Directed bench for effect_entry_arbiter in its default (non-ramped) build,
// with the entry timeout shortened to 16 cycles.
module tb_effect_entry_arbiter;

    localparam int VAL_W = 7;

    logic             Clock;
    logic             Reset;
    logic [2:0]       EffectOn;
    logic [2:0]       EffectReq;
    logic             entry_done;
    logic [VAL_W-1:0] entry_value;
    logic [2:0]       Grant;
    logic             entry_start;
    logic             entry_abort;
    logic             Busy;
    logic [VAL_W-1:0] volume_param;
    logic [VAL_W-1:0] pitch_param;
    logic [VAL_W-1:0] distortion_param;

    int checks = 0;
    int fails  = 0;

    effect_entry_arbiter #(
        .VAL_W(VAL_W),
        .MAX_VALUE(100),
        .ENTRY_TIMEOUT(24'd16),
        .RAMP_DIV(16'd2)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .EffectOn(EffectOn),
        .EffectReq(EffectReq),
        .entry_done(entry_done),
        .entry_value(entry_value),
        .Grant(Grant),
        .entry_start(entry_start),
        .entry_abort(entry_abort),
        .Busy(Busy),
        .volume_param(volume_param),
        .pitch_param(pitch_param),
        .distortion_param(distortion_param)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one cycle; afterwards outputs are settled and inputs may change.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        EffectOn    = 3'b000;
        EffectReq   = 3'b000;
        entry_done  = 1'b0;
        entry_value = '0;
        step();
        step();
        checks++;
        if ({Grant, entry_start, entry_abort, Busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want %b", {Grant, entry_start, entry_abort, Busy}, 6'b0);
        end
        checks++;
        if ({volume_param, pitch_param, distortion_param} !== 21'b0) begin
            fails++;
            $display("FAIL reset_params: got %h want 0", {volume_param, pitch_param, distortion_param});
        end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_volume();
        EffectOn  = 3'b001;
        EffectReq = 3'b001;
        step();                                   // n+1
        EffectReq = 3'b000;
        checks++;
        if (Grant !== 3'b001 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL vol_grant: got grant=%b busy=%b want 001/1", Grant, Busy);
        end
        checks++;
        if (entry_start !== 1'b0) begin
            fails++;
            $display("FAIL vol_start_early: got %b want 0", entry_start);
        end
        step();                                   // n+2
        checks++;
        if (entry_start !== 1'b1) begin
            fails++;
            $display("FAIL vol_start: got %b want 1", entry_start);
        end
        step();                                   // n+3 = m
        checks++;
        if (entry_start !== 1'b0) begin
            fails++;
            $display("FAIL vol_start_pulse: got %b want 0", entry_start);
        end
        entry_done  = 1'b1;
        entry_value = 7'd57;
        step();                                   // m+1
        entry_done = 1'b0;
        checks++;
        if (Grant !== 3'b001 || volume_param !== 7'd0) begin
            fails++;
            $display("FAIL vol_apply_cycle: got grant=%b param=%0d want 001/0", Grant, volume_param);
        end
        step();                                   // m+2
        checks++;
        if (Grant !== 3'b000 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL vol_release: got grant=%b busy=%b want 000/0", Grant, Busy);
        end
        checks++;
        if (volume_param !== 7'd57) begin
            fails++;
            $display("FAIL vol_param: got %0d want 57", volume_param);
        end
    endtask

    // Pitch and distortion request together right after a volume session.
    task automatic test_round_robin_clamp();
        EffectOn  = 3'b111;
        EffectReq = 3'b110;
        step();
        checks++;
        if (Grant !== 3'b010) begin
            fails++;
            $display("FAIL rr_pitch_first: got %b want 010", Grant);
        end
        step();                                   // WAIT
        entry_done  = 1'b1;
        entry_value = 7'd33;
        step();                                   // APPLY
        entry_done = 1'b0;
        step();                                   // IDLE, requests still high
        checks++;
        if (Grant !== 3'b000 || pitch_param !== 7'd33) begin
            fails++;
            $display("FAIL rr_pitch_done: got grant=%b param=%0d want 000/33", Grant, pitch_param);
        end
        step();
        EffectReq = 3'b000;
        checks++;
        if (Grant !== 3'b100) begin
            fails++;
            $display("FAIL rr_dist_next: got %b want 100", Grant);
        end
        step();                                   // WAIT
        entry_done  = 1'b1;
        entry_value = 7'd120;
        step();                                   // APPLY
        entry_done = 1'b0;
        step();
        checks++;
        if (distortion_param !== 7'd100) begin
            fails++;
            $display("FAIL clamp_120: got %0d want 100", distortion_param);
        end
        checks++;
        if (volume_param !== 7'd57 || pitch_param !== 7'd33) begin
            fails++;
            $display("FAIL rr_others_kept: got vol=%0d pitch=%0d want 57/33", volume_param, pitch_param);
        end
    endtask

    // Owner disabled mid-session, with a coincident entry_done that must be dropped.
    task automatic test_owner_drop();
        EffectReq = 3'b010;
        step();
        EffectReq = 3'b000;
        checks++;
        if (Grant !== 3'b010) begin
            fails++;
            $display("FAIL drop_grant: got %b want 010", Grant);
        end
        step();                                   // WAIT
        EffectOn    = 3'b101;
        entry_done  = 1'b1;
        entry_value = 7'd50;
        step();
        entry_done = 1'b0;
        checks++;
        if (entry_abort !== 1'b1 || Grant !== 3'b010) begin
            fails++;
            $display("FAIL drop_abort: got abort=%b grant=%b want 1/010", entry_abort, Grant);
        end
        checks++;
        if (pitch_param !== 7'd0) begin
            fails++;
            $display("FAIL drop_target_zero: got %0d want 0", pitch_param);
        end
        step();
        checks++;
        if (entry_abort !== 1'b0 || Grant !== 3'b000 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_release: got abort=%b grant=%b busy=%b want 0/000/0", entry_abort, Grant, Busy);
        end
        step();
        checks++;
        if (pitch_param !== 7'd0) begin
            fails++;
            $display("FAIL drop_value_discarded: got %0d want 0", pitch_param);
        end
    endtask

    // Session with no entry_done: counter runs 0..15, abort appears 16 cycles after entry_start.
    task automatic test_timeout();
        int early_abort;
        EffectOn  = 3'b111;
        EffectReq = 3'b100;
        step();
        EffectReq = 3'b000;
        checks++;
        if (Grant !== 3'b100) begin
            fails++;
            $display("FAIL to_grant: got %b want 100", Grant);
        end
        step();                                   // entry_start cycle
        checks++;
        if (entry_start !== 1'b1) begin
            fails++;
            $display("FAIL to_start: got %b want 1", entry_start);
        end
        early_abort = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (entry_abort !== 1'b0) early_abort++;
        end
        checks++;
        if (early_abort != 0) begin
            fails++;
            $display("FAIL to_early_abort: got %0d cycles with abort want 0", early_abort);
        end
        step();
        checks++;
        if (entry_abort !== 1'b1 || Grant !== 3'b100) begin
            fails++;
            $display("FAIL to_abort: got abort=%b grant=%b want 1/100", entry_abort, Grant);
        end
        step();
        checks++;
        if (entry_abort !== 1'b0 || Grant !== 3'b000) begin
            fails++;
            $display("FAIL to_release: got abort=%b grant=%b want 0/000", entry_abort, Grant);
        end
        checks++;
        if (distortion_param !== 7'd100) begin
            fails++;
            $display("FAIL to_target_kept: got %0d want 100", distortion_param);
        end
    endtask

    task automatic test_reset_mid_session();
        int stray_abort;
        EffectReq = 3'b001;
        step();
        EffectReq = 3'b000;
        step();                                   // WAIT
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Grant, entry_start, entry_abort, Busy} !== 6'b0) begin
            fails++;
            $display("FAIL rst_mid_ctrl: got %b want %b", {Grant, entry_start, entry_abort, Busy}, 6'b0);
        end
        checks++;
        if ({volume_param, pitch_param, distortion_param} !== 21'b0) begin
            fails++;
            $display("FAIL rst_mid_params: got %h want 0", {volume_param, pitch_param, distortion_param});
        end
        step();
        Reset = 1'b0;
        stray_abort = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (entry_abort !== 1'b0 || Grant !== 3'b000) stray_abort++;
        end
        checks++;
        if (stray_abort != 0) begin
            fails++;
            $display("FAIL rst_no_abort: got %0d bad cycles want 0", stray_abort);
        end
        EffectReq = 3'b101;
        step();
        EffectReq = 3'b000;
        checks++;
        if (Grant !== 3'b001) begin
            fails++;
            $display("FAIL rst_regrant: got %b want 001", Grant);
        end
        step();
        checks++;
        if (entry_start !== 1'b1) begin
            fails++;
            $display("FAIL rst_restart: got %b want 1", entry_start);
        end
        entry_done  = 1'b1;
        entry_value = 7'd99;
        step();
        entry_done = 1'b0;
        step();
        checks++;
        if (volume_param !== 7'd99 || Grant !== 3'b000) begin
            fails++;
            $display("FAIL rst_session: got param=%0d grant=%b want 99/000", volume_param, Grant);
        end
    endtask

    initial begin
        test_reset();
        test_volume();
        test_round_robin_clamp();
        test_owner_drop();
        test_timeout();
        test_reset_mid_session();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
